// File: rtl/wb_stage.sv
// wb_stage: MEM->WB stage register, waits for late load data, optional sub-word load alignment/extension (WB_LOAD_EXT_EN).
// Latency: one edge from MEM capture to rf write; a load commits in the cycle dm_rvalid is high.
// Backpressure: wb_stall is combinational and stays high while a held load has no dm_rvalid.
module wb_stage #(
    parameter int DATA_BITS = 32,
    parameter int REG_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic [DATA_BITS-1:0] rd_data,
    input  logic [REG_BITS-1:0]  rd_addr,
    input  logic                 reg_wr,
    input  logic                 dm2reg,
    input  logic [2:0]           ld_funct3,
    input  logic [1:0]           ld_addr_lo,
    input  logic [DATA_BITS-1:0] dm_out,
    input  logic                 dm_rvalid,
    input  logic                 wb_flush,
    output logic                 rf_we,
    output logic [REG_BITS-1:0]  rf_waddr,
    output logic [DATA_BITS-1:0] rf_wdata,
    output logic                 wb_stall
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HOLD    = 2'd1,
        WAIT_DM = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [DATA_BITS-1:0]   q_rd_data;
    logic [REG_BITS-1:0]    q_rd_addr;
    logic                   q_reg_wr;
    logic                   q_dm2reg;
    logic [DATA_BITS-1:0]   ld_data;
    logic                   capture;

    assign capture = !wb_stall && mem_valid && !wb_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!wb_stall) begin
            if (capture) begin
                state_nxt = dm2reg ? WAIT_DM : HOLD;
            end else begin
                state_nxt = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_rd_data <= '0;
            q_rd_addr <= '0;
            q_reg_wr  <= 1'b0;
            q_dm2reg  <= 1'b0;
        end else if (capture) begin
            q_rd_data <= rd_data;
            q_rd_addr <= rd_addr;
            q_reg_wr  <= reg_wr;
            q_dm2reg  <= dm2reg;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  q_funct3;
    logic [1:0]  q_addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_funct3  <= 3'b000;
            q_addr_lo <= 2'b00;
        end else if (capture) begin
            q_funct3  <= ld_funct3;
            q_addr_lo <= ld_addr_lo;
        end
    end

    // Halfword select uses only addr bit 1; misaligned bit 0 is ignored.
    always_comb begin
        ld_byte = dm_out[{q_addr_lo, 3'b000} +: 8];
        ld_half = q_addr_lo[1] ? dm_out[31:16] : dm_out[15:0];
        case (q_funct3)
            3'b000:  ld_data = {{(DATA_BITS-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATA_BITS-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATA_BITS-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATA_BITS-16){1'b0}}, ld_half};
            default: ld_data = dm_out;
        endcase
    end
`else
    // MEM stage already extended the data; load-type inputs are deliberately dropped.
    logic unused_ld_info;
    assign unused_ld_info = ^{ld_funct3, ld_addr_lo};
    assign ld_data        = dm_out;
`endif

    always_comb begin
        wb_stall = (state == WAIT_DM) && !dm_rvalid;
        rf_we    = q_reg_wr && (q_rd_addr != '0) &&
                   ((state == HOLD) || ((state == WAIT_DM) && dm_rvalid));
        rf_waddr = q_rd_addr;
        rf_wdata = q_dm2reg ? ld_data : q_rd_data;
    end

endmodule
